// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory port between instruction fetch (I) and data access (D).
//   One transaction in flight at a time. D has priority, but after MAX_D_STREAK
//   consecutive D grants with a fetch waiting, the fetch gets the next grant.
//   A fetch flushed while in flight still completes on the memory side; its
//   response is dropped.
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   if_req/if_addr/flush_F   fetch request, address, fetch kill
//   if_rvalid/if_rdata       fetch response pulse and data
//   if_stall                 if_req & ~if_rvalid
//   dm_req/dm_we/dm_be/      data request, store flag, byte enables,
//   dm_addr/dm_wdata         address and store data
//   dm_rvalid/dm_rdata       data response pulse and load data
//   dm_stall                 dm_req & ~dm_rvalid
//   mem_req_valid/ready      request handshake to memory
//   mem_addr/we/be/wdata     registered request fields
//   mem_rsp_valid/mem_rdata  memory response
module mem_port_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                flush_F,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_stall,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [DATA_W/8-1:0] dm_be,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    output logic                dm_rvalid,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                dm_stall,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int unsigned STREAK_W = $clog2(MAX_D_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;
    typedef enum logic {OwnI, OwnD} owner_e;

    state_e              state_q;
    owner_e              owner_q;
    logic [STREAK_W-1:0] streak_q;
    logic                kill_q;

    logic grant_d;
    logic grant_i;
    logic fetch_flush;

    always_comb begin
        // No grant in the IDLE cycle that carries a response pulse: the
        // requester is still presenting the request that just completed.
        grant_d = (state_q == StIdle) && !(if_rvalid || dm_rvalid) && dm_req &&
                  (!if_req || (streak_q < STREAK_MAX));
        grant_i = (state_q == StIdle) && !(if_rvalid || dm_rvalid) && !grant_d &&
                  if_req && !flush_F;
        fetch_flush = flush_F && (owner_q == OwnI);
    end

    assign if_stall = if_req & ~if_rvalid;
    assign dm_stall = dm_req & ~dm_rvalid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            owner_q       <= OwnI;
            streak_q      <= '0;
            kill_q        <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_addr      <= '0;
            mem_we        <= 1'b0;
            mem_be        <= '0;
            mem_wdata     <= '0;
            if_rvalid     <= 1'b0;
            if_rdata      <= '0;
            dm_rvalid     <= 1'b0;
            dm_rdata      <= '0;
        end else begin
            if_rvalid <= 1'b0;
            dm_rvalid <= 1'b0;

            // Counts D grants that overtook a waiting fetch.
            if (!if_req || grant_i) begin
                streak_q <= '0;
            end else if (grant_d && (streak_q < STREAK_MAX)) begin
                streak_q <= streak_q + 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (grant_d) begin
                        owner_q       <= OwnD;
                        mem_addr      <= dm_addr;
                        mem_we        <= dm_we;
                        mem_be        <= dm_we ? dm_be : '0;
                        mem_wdata     <= dm_we ? dm_wdata : '0;
                        mem_req_valid <= 1'b1;
                        state_q       <= StReq;
                    end else if (grant_i) begin
                        owner_q       <= OwnI;
                        mem_addr      <= if_addr;
                        mem_we        <= 1'b0;
                        mem_be        <= '0;
                        mem_wdata     <= '0;
                        mem_req_valid <= 1'b1;
                        state_q       <= StReq;
                    end
                end
                StReq: begin
                    if (fetch_flush) begin
                        kill_q <= 1'b1;
                    end
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state_q       <= StWait;
                    end
                end
                StWait: begin
                    if (fetch_flush) begin
                        kill_q <= 1'b1;
                    end
                    if (mem_rsp_valid) begin
                        state_q <= StIdle;
                        kill_q  <= 1'b0;
                        if (owner_q == OwnD) begin
                            dm_rdata  <= mem_rdata;
                            dm_rvalid <= 1'b1;
                        end else if (!(kill_q || flush_F)) begin
                            // A flush arriving with the response also drops it.
                            if_rdata  <= mem_rdata;
                            if_rvalid <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int MAXS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        flush_F;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_stall;
    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic        dm_stall;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] exp_ird;
    logic [31:0] exp_drd;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .MAX_D_STREAK(MAXS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .flush_F      (flush_F),
        .if_rvalid    (if_rvalid),
        .if_rdata     (if_rdata),
        .if_stall     (if_stall),
        .dm_req       (dm_req),
        .dm_we        (dm_we),
        .dm_be        (dm_be),
        .dm_addr      (dm_addr),
        .dm_wdata     (dm_wdata),
        .dm_rvalid    (dm_rvalid),
        .dm_rdata     (dm_rdata),
        .dm_stall     (dm_stall),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_be       (mem_be),
        .mem_wdata    (mem_wdata),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rdata    (mem_rdata)
    );

    typedef struct {
        bit          is_d;
        bit          we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rsp;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        if_req        = 1'b0;
        if_addr       = '0;
        flush_F       = 1'b0;
        dm_req        = 1'b0;
        dm_we         = 1'b0;
        dm_be         = '0;
        dm_addr       = '0;
        dm_wdata      = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rdata     = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " mem_req_valid"}, 32'(mem_req_valid), 32'd0);
        chk({tag, " if_rvalid"}, 32'(if_rvalid), 32'd0);
        chk({tag, " dm_rvalid"}, 32'(dm_rvalid), 32'd0);
        chk({tag, " if_rdata"}, if_rdata, 32'd0);
        chk({tag, " dm_rdata"}, dm_rdata, 32'd0);
        chk({tag, " mem_addr"}, mem_addr, 32'd0);
        chk({tag, " mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, " mem_be"}, 32'(mem_be), 32'd0);
        chk({tag, " mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, " if_stall"}, 32'(if_stall), 32'd0);
        chk({tag, " dm_stall"}, 32'(dm_stall), 32'd0);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_ird = '0;
        exp_drd = '0;
    endtask

    // One transaction with an always-ready memory; latency counted from the
    // grant cycle (the cycle the request is first presented).
    task automatic run_vec(input vec_t v, input string tag);
        int k;
        bit seen;
        idle_inputs();
        if (v.is_d) begin
            dm_req   = 1'b1;
            dm_we    = v.we;
            dm_be    = v.be;
            dm_addr  = v.addr;
            dm_wdata = v.wdata;
            if_addr  = 32'h0BAD_1000;
        end else begin
            if_req   = 1'b1;
            if_addr  = v.addr;
            dm_we    = 1'b1;
            dm_be    = 4'hF;
            dm_addr  = 32'h0BAD_0000;
            dm_wdata = 32'h0BAD_DA7A;
        end
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rdata     = v.rsp;
        k = 0;
        seen = 1'b0;
        while (!seen && k < 8) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                chk({tag, " req valid"}, 32'(mem_req_valid), 32'd1);
                chk({tag, " mem_addr"}, mem_addr, v.addr);
                chk({tag, " mem_we"}, 32'(mem_we), v.is_d ? 32'(v.we) : 32'd0);
                chk({tag, " mem_be"}, 32'(mem_be), 32'(v.exp_be));
                chk({tag, " mem_wdata"}, mem_wdata, v.exp_wdata);
                chk({tag, " stall"}, 32'(v.is_d ? dm_stall : if_stall), 32'd1);
            end
            if (if_rvalid || dm_rvalid) seen = 1'b1;
        end
        chk({tag, " latency"}, 32'(k), 32'd3);
        chk({tag, " dm_rvalid"}, 32'(dm_rvalid), v.is_d ? 32'd1 : 32'd0);
        chk({tag, " if_rvalid"}, 32'(if_rvalid), v.is_d ? 32'd0 : 32'd1);
        chk({tag, " stall at rvalid"}, 32'(v.is_d ? dm_stall : if_stall), 32'd0);
        if (v.is_d) exp_drd = v.rsp;
        else exp_ird = v.rsp;
        chk({tag, " dm_rdata"}, dm_rdata, exp_drd);
        chk({tag, " if_rdata"}, if_rdata, exp_ird);
        idle_inputs();
        @(negedge clk);
        chk({tag, " pulse is one cycle"}, 32'(if_rvalid | dm_rvalid), 32'd0);
    endtask

    // Random-phase reference model state
    bit          m_busy;
    bit          m_acc;
    bit          m_own_d;
    int          m_streak;
    logic        e_valid;
    logic        e_iv;
    logic        e_dv;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_we;
    logic [3:0]  e_be;
    bit          mem_pend;
    int          mem_dly;

    initial begin
        logic [9:0] seq_d;
        int         g;
        int         n;
        logic       prev;
        bit         pulse_now;
        bit         cur_iv;
        bit         cur_dv;
        bit         gd;
        bit         gi;

        vecs[0] = '{1'b1, 1'b0, 4'hF, 32'h0000_0100, 32'h1111_1111, 32'hDEAD_BEEF, 4'h0, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 4'h3, 32'h0000_0204, 32'hAABB_CCDD, 32'h0000_0000, 4'h3,
                    32'hAABB_CCDD};
        vecs[2] = '{1'b0, 1'b0, 4'h0, 32'h0000_0040, 32'h0, 32'h1357_9BDF, 4'h0, 32'h0};
        vecs[3] = '{1'b1, 1'b1, 4'h8, 32'h0000_FFFC, 32'h0102_0304, 32'hCAFE_F00D, 4'h8,
                    32'h0102_0304};
        vecs[4] = '{1'b1, 1'b0, 4'hA, 32'h0000_0000, 32'h0000_0055, 32'h0000_0000, 4'h0, 32'h0};
        vecs[5] = '{1'b0, 1'b0, 4'h0, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFF, 4'h0, 32'h0};

        idle_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        exp_ird = '0;
        exp_drd = '0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Simultaneous requests: D first, I on the IDLE cycle after dm_rvalid
        idle_inputs();
        if_req = 1'b1;
        if_addr = 32'h0000_0200;
        dm_req = 1'b1;
        dm_addr = 32'h0000_0300;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rdata = 32'h1111_2222;
        @(negedge clk);
        chk("both first grant", mem_addr, 32'h0000_0300);
        repeat (2) @(negedge clk);
        chk("both dm_rvalid", 32'(dm_rvalid), 32'd1);
        chk("both dm_rdata", dm_rdata, 32'h1111_2222);
        chk("both if_stall held", 32'(if_stall), 32'd1);
        dm_req = 1'b0;
        mem_rdata = 32'h3333_4444;
        @(negedge clk);
        chk("both no grant in pulse", 32'(mem_req_valid), 32'd0);
        chk("both no extra rvalid", 32'(if_rvalid | dm_rvalid), 32'd0);
        @(negedge clk);
        chk("both second grant valid", 32'(mem_req_valid), 32'd1);
        chk("both second grant addr", mem_addr, 32'h0000_0200);
        repeat (2) @(negedge clk);
        chk("both if_rvalid", 32'(if_rvalid), 32'd1);
        chk("both if_rdata", if_rdata, 32'h3333_4444);
        chk("both dm_rdata kept", dm_rdata, 32'h1111_2222);
        exp_ird = 32'h3333_4444;
        exp_drd = 32'h1111_2222;
        idle_inputs();
        @(negedge clk);

        // Streak limit: D,D,D,D,I repeating while both requests stay high
        idle_inputs();
        if_req = 1'b1;
        if_addr = 32'h0000_0400;
        dm_req = 1'b1;
        dm_addr = 32'h0000_0500;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rdata = 32'h5555_0000;
        seq_d = 10'b1111011110;
        g = 0;
        prev = 1'b0;
        for (int c = 0; c < 60 && g < 10; c++) begin
            @(negedge clk);
            if (mem_req_valid && !prev) begin
                chk($sformatf("streak grant %0d", g), mem_addr,
                    seq_d[9-g] ? 32'h0000_0500 : 32'h0000_0400);
                g++;
            end
            prev = mem_req_valid;
        end
        chk("streak grant count", 32'(g), 32'd10);
        if_req = 1'b0;
        dm_req = 1'b0;
        repeat (4) @(negedge clk);
        exp_ird = 32'h5555_0000;
        exp_drd = 32'h5555_0000;
        chk("streak if_rdata", if_rdata, exp_ird);
        idle_inputs();
        @(negedge clk);

        // Flush while the fetch sits in REQ
        if_req = 1'b1;
        if_addr = 32'h0000_00C0;
        mem_rsp_valid = 1'b1;
        mem_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        chk("flreq valid", 32'(mem_req_valid), 32'd1);
        flush_F = 1'b1;
        if_req = 1'b0;
        @(negedge clk);
        chk("flreq valid not withdrawn", 32'(mem_req_valid), 32'd1);
        flush_F = 1'b0;
        mem_req_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("flreq no if_rvalid", 32'(if_rvalid), 32'd0);
        chk("flreq done", 32'(mem_req_valid), 32'd0);
        @(negedge clk);
        chk("flreq no late rvalid", 32'(if_rvalid), 32'd0);
        chk("flreq if_rdata kept", if_rdata, exp_ird);
        idle_inputs();
        @(negedge clk);

        // Flush while the fetch sits in WAIT, then a normal fetch
        if_req = 1'b1;
        if_addr = 32'h0000_0040;
        mem_req_ready = 1'b1;
        mem_rdata = 32'h1234_5678;
        repeat (2) @(negedge clk);
        flush_F = 1'b1;
        if_req = 1'b0;
        @(negedge clk);
        flush_F = 1'b0;
        mem_rsp_valid = 1'b1;
        @(negedge clk);
        chk("flwait no if_rvalid", 32'(if_rvalid), 32'd0);
        chk("flwait if_rdata kept", if_rdata, exp_ird);
        chk("flwait idle", 32'(mem_req_valid), 32'd0);
        if_req = 1'b1;
        if_addr = 32'h0000_0080;
        mem_rdata = 32'h9ABC_DEF0;
        n = 0;
        while (!if_rvalid && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("refetch latency", 32'(n), 32'd3);
        chk("refetch if_rvalid", 32'(if_rvalid), 32'd1);
        chk("refetch if_rdata", if_rdata, 32'h9ABC_DEF0);
        exp_ird = 32'h9ABC_DEF0;
        idle_inputs();
        @(negedge clk);

        // Flush with D owning the port has no effect
        dm_req = 1'b1;
        dm_addr = 32'h0000_0600;
        mem_req_ready = 1'b1;
        repeat (2) @(negedge clk);
        flush_F = 1'b1;
        @(negedge clk);
        flush_F = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rdata = 32'h0D0D_0D0D;
        @(negedge clk);
        chk("dflush dm_rvalid", 32'(dm_rvalid), 32'd1);
        chk("dflush dm_rdata", dm_rdata, 32'h0D0D_0D0D);
        exp_drd = 32'h0D0D_0D0D;
        idle_inputs();
        @(negedge clk);

        // Store with memory not ready for several cycles, stray responses
        dm_req = 1'b1;
        dm_we = 1'b1;
        dm_be = 4'b0011;
        dm_addr = 32'h0000_0700;
        dm_wdata = 32'hAABB_CCDD;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk($sformatf("stall%0d valid", k), 32'(mem_req_valid), 32'd1);
            chk($sformatf("stall%0d addr", k), mem_addr, 32'h0000_0700);
            chk($sformatf("stall%0d we", k), 32'(mem_we), 32'd1);
            chk($sformatf("stall%0d be", k), 32'(mem_be), 32'h3);
            chk($sformatf("stall%0d wdata", k), mem_wdata, 32'hAABB_CCDD);
            chk($sformatf("stall%0d dm_rvalid", k), 32'(dm_rvalid), 32'd0);
            mem_rsp_valid = (k == 2);
            mem_rdata = 32'hBAD0_0001;
            mem_req_ready = (k == 6);
        end
        @(negedge clk);
        chk("store in wait", 32'(mem_req_valid), 32'd0);
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rdata = 32'h0000_ACED;
        @(negedge clk);
        chk("store dm_rvalid", 32'(dm_rvalid), 32'd1);
        chk("store dm_rdata", dm_rdata, 32'h0000_ACED);
        chk("store dm_stall", 32'(dm_stall), 32'd0);
        exp_drd = 32'h0000_ACED;
        dm_req = 1'b0;
        mem_rsp_valid = 1'b0;
        @(negedge clk);
        mem_rsp_valid = 1'b1;
        mem_rdata = 32'hBAD0_0002;
        @(negedge clk);
        chk("stray idle dm_rvalid", 32'(dm_rvalid), 32'd0);
        chk("stray idle if_rvalid", 32'(if_rvalid), 32'd0);
        chk("stray idle dm_rdata", dm_rdata, exp_drd);
        idle_inputs();
        @(negedge clk);

        // Reset while waiting for a response
        dm_req = 1'b1;
        dm_addr = 32'h0000_0800;
        mem_req_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        dm_req = 1'b0;
        mem_req_ready = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst in wait");
        rst = 1'b0;
        exp_ird = '0;
        exp_drd = '0;
        mem_rsp_valid = 1'b1;
        mem_rdata = 32'hBAD0_0003;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post-rst rvalid", 32'(if_rvalid | dm_rvalid), 32'd0);
            chk("post-rst dm_rdata", dm_rdata, 32'd0);
        end
        idle_inputs();
        run_vec(vecs[0], "post-rst vec");

        // Randomized traffic against a transaction-level model
        do_reset();
        m_busy = 0;
        m_acc = 0;
        m_own_d = 0;
        m_streak = 0;
        e_valid = 0;
        e_iv = 0;
        e_dv = 0;
        e_addr = '0;
        e_wdata = '0;
        e_we = 0;
        e_be = '0;
        mem_pend = 0;
        mem_dly = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            chk("rnd mem_req_valid", 32'(mem_req_valid), 32'(e_valid));
            chk("rnd mem_addr", mem_addr, e_addr);
            chk("rnd mem_we", 32'(mem_we), 32'(e_we));
            chk("rnd mem_be", 32'(mem_be), 32'(e_be));
            chk("rnd mem_wdata", mem_wdata, e_wdata);
            chk("rnd if_rvalid", 32'(if_rvalid), 32'(e_iv));
            chk("rnd dm_rvalid", 32'(dm_rvalid), 32'(e_dv));
            chk("rnd if_rdata", if_rdata, exp_ird);
            chk("rnd dm_rdata", dm_rdata, exp_drd);
            cur_iv = e_iv;
            cur_dv = e_dv;
            pulse_now = e_iv || e_dv;

            // Requesters hold until their response, then maybe issue again
            if (if_req && if_rvalid) if_req = ($urandom_range(0, 1) == 0);
            else if (!if_req) if_req = ($urandom_range(0, 1) == 0);
            else if_req = 1'b1;
            if (if_req && !(if_req && !if_rvalid && if_addr[1:0] == 2'b01)) begin
                if (if_rvalid || if_addr[1:0] != 2'b01) if_addr = {$urandom_range(0, 65535), 14'h0, 2'b01};
            end
            if (dm_req && dm_rvalid) dm_req = ($urandom_range(0, 3) != 0);
            else if (!dm_req) dm_req = ($urandom_range(0, 3) != 0);
            if (dm_req && (dm_rvalid || dm_addr[1:0] != 2'b10)) begin
                dm_we = $urandom_range(0, 1) == 1;
                dm_be = 4'($urandom_range(0, 15));
                dm_addr = {$urandom_range(0, 65535), 14'h0, 2'b10};
                dm_wdata = $urandom;
            end

            // Memory: random ready, response 0..3 cycles into WAIT, strays otherwise
            mem_req_ready = ($urandom_range(0, 2) != 0);
            if (mem_pend) begin
                if (mem_dly == 0) begin
                    mem_rsp_valid = 1'b1;
                    mem_rdata = $urandom;
                    mem_pend = 0;
                end else begin
                    mem_rsp_valid = 1'b0;
                    mem_dly--;
                end
            end else begin
                mem_rsp_valid = ($urandom_range(0, 7) == 0);
                mem_rdata = $urandom;
            end
            if (mem_req_valid && mem_req_ready) begin
                mem_pend = 1;
                mem_dly = $urandom_range(0, 3);
            end

            #1;
            chk("rnd if_stall", 32'(if_stall), 32'(if_req && !cur_iv));
            chk("rnd dm_stall", 32'(dm_stall), 32'(dm_req && !cur_dv));

            // Model: who gets the port next, and what comes back when
            gd = 0;
            gi = 0;
            if (!m_busy && !pulse_now) begin
                if (dm_req && (!if_req || m_streak < MAXS)) gd = 1;
                else if (if_req) gi = 1;
            end
            e_iv = 0;
            e_dv = 0;
            if (m_busy && m_acc && mem_rsp_valid) begin
                if (m_own_d) begin
                    e_dv = 1;
                    exp_drd = mem_rdata;
                end else begin
                    e_iv = 1;
                    exp_ird = mem_rdata;
                end
                m_busy = 0;
                m_acc = 0;
            end else if (m_busy && !m_acc && mem_req_ready) begin
                m_acc = 1;
            end
            if (gd || gi) begin
                m_busy = 1;
                m_acc = 0;
                m_own_d = gd;
                e_addr = gd ? dm_addr : if_addr;
                e_we = gd ? dm_we : 1'b0;
                e_be = (gd && dm_we) ? dm_be : 4'h0;
                e_wdata = (gd && dm_we) ? dm_wdata : 32'h0;
            end
            if (!if_req || gi) m_streak = 0;
            else if (gd && m_streak < MAXS) m_streak++;
            e_valid = m_busy && !m_acc;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
